// File: rtl/bus_arbiter_if.sv
// Two-master request/response signals plus the shared slave bus, as seen by the arbiter.
interface bus_arbiter_if;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_re, m0_ack, m0_err;
  logic [3:0]  m0_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_re, m1_ack, m1_err;
  logic [3:0]  m1_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_re, bus_ready;
  logic [3:0]  bus_we;

  // Arbiter side: takes requests, answers masters, drives the shared bus.
  modport slave (
    input  m0_addr, m0_re, m0_we, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_addr, m1_re, m1_we, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output bus_addr, bus_re, bus_we, bus_wdata,
    input  bus_rdata, bus_ready
  );

  // Environment side: the two masters and the selected slave.
  modport master (
    output m0_addr, m0_re, m0_we, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_addr, m1_re, m1_we, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  bus_addr, bus_re, bus_we, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/bus_arbiter.sv
// Fetch/data master arbiter onto one shared bus: round-robin on contention,
// one transfer at a time, with a bounded wait for slave ready.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  bus_arbiter_if.slave bif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             owner, last_grant, grant;
  logic [3:0]       wcnt;
  logic [1:0]       req, ack, err;
  logic [1:0][31:0] rdata;

  logic [31:0] o_addr, o_wdata;
  logic        o_re;
  logic [3:0]  o_we;

  assign req[0] = bif.m0_re | (|bif.m0_we);
  assign req[1] = bif.m1_re | (|bif.m1_we);

  // Lone requester wins; on a tie the master that did not win last time wins.
  assign grant = (&req) ? ~last_grant : req[1];

  assign o_addr  = owner ? bif.m1_addr  : bif.m0_addr;
  assign o_re    = owner ? bif.m1_re    : bif.m0_re;
  assign o_we    = owner ? bif.m1_we    : bif.m0_we;
  assign o_wdata = owner ? bif.m1_wdata : bif.m0_wdata;

  always_comb begin
    bif.bus_addr  = '0;
    bif.bus_re    = 1'b0;
    bif.bus_we    = '0;
    bif.bus_wdata = '0;
    if (state == BUSY) begin
      bif.bus_addr  = o_addr;
      bif.bus_re    = o_re & ~(|o_we);
      bif.bus_we    = o_we;
      bif.bus_wdata = o_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      wcnt       <= '0;
      ack        <= '0;
      err        <= '0;
      rdata      <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: if (|req) begin
          owner      <= grant;
          last_grant <= grant;
          wcnt       <= '0;
          state      <= BUSY;
        end
        BUSY: begin
          // Ready takes priority over an expiring wait counter.
          if (bif.bus_ready) begin
            state        <= DONE;
            ack[owner]   <= 1'b1;
            rdata[owner] <= bif.bus_rdata;
          end else if (wcnt == TLAST) begin
            state        <= DONE;
            ack[owner]   <= 1'b1;
            err[owner]   <= 1'b1;
            rdata[owner] <= '0;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bif.m0_ack   = ack[0];
  assign bif.m1_ack   = ack[1];
  assign bif.m0_err   = err[0];
  assign bif.m1_err   = err[1];
  assign bif.m0_rdata = rdata[0];
  assign bif.m1_rdata = rdata[1];
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles allowed without bus_ready (range 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port m0_addr  in  32  fetch-master address.
REQ-005 SHALL have port m0_re  in  1  fetch-master read request.
REQ-006 SHALL have port m0_we  in  4  fetch-master byte write enables.
REQ-007 SHALL have port m0_wdata  in  32  fetch-master write data.
REQ-008 SHALL have port m0_ack  out  1  fetch-master one-cycle completion pulse.
REQ-009 SHALL have port m0_err  out  1  fetch-master timeout flag, valid with m0_ack.
REQ-010 SHALL have port m0_rdata  out  32  fetch-master read data, valid with m0_ack.
REQ-011 SHALL have ports m1_addr, m1_re, m1_we, m1_wdata, m1_ack, m1_err and m1_rdata, with the same directions and widths as the m0 ports, for the data (load/store) master.
REQ-012 SHALL have port bus_addr  out  32  shared bus address, feeding the address decoder.
REQ-013 SHALL have port bus_re  out  1  shared bus read strobe.
REQ-014 SHALL have port bus_we  out  4  shared bus byte write strobes.
REQ-015 SHALL have port bus_wdata  out  32  shared bus write data.
REQ-016 SHALL have port bus_rdata  in  32  read data returned by the selected slave.
REQ-017 SHALL have port bus_ready  in  1  slave completion; sampled only in BUSY.

Function
REQ-018 Request from master N SHALL be defined as mN_re | (|mN_we); a master holds addr/re/we/wdata stable from request until it sees ack.
REQ-019 SHALL implement states IDLE, BUSY and DONE, plus an owner register (0/1), a last_grant register and a 4-bit wait counter.
REQ-020 IDLE: with no request, SHALL stay in IDLE; with any request, SHALL load owner and go to BUSY next cycle.
REQ-021 Arbitration SHALL grant the sole requester; if both request, SHALL grant the master not equal to last_grant; last_grant SHALL update to the winner.
REQ-022 BUSY: SHALL drive the owner's addr/we/wdata combinationally onto the bus, with bus_re = owner_re & ~(|owner_we), so write wins if both are set.
REQ-023 IDLE and DONE: bus_addr, bus_re, bus_we and bus_wdata SHALL all be 0.
REQ-024 BUSY with bus_ready=1: SHALL latch bus_rdata into owner's rdata, go to DONE and assert owner ack (err=0) during DONE.
REQ-025 Wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without bus_ready.
REQ-026 When the counter reaches TIMEOUT-1 without bus_ready, SHALL go to DONE with owner ack=1, err=1 and rdata=0.
REQ-027 If bus_ready and timeout coincide, bus_ready SHALL win and err SHALL be 0.
REQ-028 DONE SHALL last exactly one cycle then return to IDLE; ack and err SHALL be registered one-cycle pulses, and only the owner's ack may assert.
REQ-029 mN_rdata SHALL hold its last latched value until the next completion for that master.
REQ-030 Minimum latency SHALL be: request sampled in cycle 0, BUSY in cycle 1 (bus_ready=1), ack in cycle 2, IDLE in cycle 3 where a new request may be sampled.
REQ-031 A master SHALL drop or change its request in the cycle after ack; a request still present in IDLE is treated as a new transaction.
REQ-032 The non-owner's request SHALL be ignored until IDLE; no request is lost or reordered for a single master.

Reset
REQ-033 With rst=1 at a clock edge, in any state including mid-BUSY, SHALL set state=IDLE, owner=0, last_grant=0, counter=0, all ack/err=0, all rdata=0.
REQ-034 Bus outputs SHALL be 0 from the cycle after the reset edge; an interrupted transaction SHALL produce no ack.
REQ-035 After reset, the first simultaneous request SHALL be granted to m1.

Verification
REQ-036 Single read: m0_re=1, m0_addr=0x10000004, bus_ready=1 in the first BUSY cycle, bus_rdata=0xDEADBEEF -> bus_re=1 in cycle 1; m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 2 only.
REQ-037 Contention after reset: m0 and m1 request in the same cycle -> m1 served first, then m0; then both request again -> m1 served, alternating.
REQ-038 Write with re also set: m1_we=4'b0011, m1_re=1, m1_wdata=0x1234 -> bus_we=4'b0011, bus_re=0, bus_wdata=0x1234; m1_ack with m1_err=0.
REQ-039 Timeout: bus_ready held 0 with TIMEOUT=16 -> ack and err pulse after 16 BUSY cycles, rdata=0; then return to IDLE; also bus_ready=1 on the final BUSY cycle -> err=0.
REQ-040 Reset mid-BUSY: rst=1 on the third BUSY cycle -> next cycle all bus outputs 0 and state IDLE, with no ack/err ever issued for the aborted transfer.
